// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module : pipeline_hazard_ctrl_pkg
// Brief  : Shared stop-reason codes, FSM encoding and register constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    localparam logic [3:0] STOP_NONE    = 4'b0000;
    localparam logic [3:0] STOP_LOADUSE = 4'b0001;
    localparam logic [3:0] STOP_MEMWAIT = 4'b0010;
    localparam logic [3:0] STOP_FLUSH   = 4'b0100;
    localparam logic [3:0] STOP_TIMEOUT = 4'b1000;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module : pipeline_hazard_ctrl_if
// Brief  : Core <-> hazard controller signal bundle (master = core side).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd;
    logic             ex_we;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             pipeline_stop;
    logic [3:0]       stop_info;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             freeze_all;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_we, ex_is_load, ex_redirect, mem_req, mem_ack,
        input  pipeline_stop, stop_info, flush_if_id, flush_id_ex,
               freeze_all, timeout_err, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_rd, ex_we, ex_is_load, ex_redirect, mem_req, mem_ack,
        output pipeline_stop, stop_info, flush_if_id, flush_id_ex,
               freeze_all, timeout_err, stall_cycles
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ============================================================================
// Module : pipeline_hazard_ctrl_hazard_detect
// Brief  : Combinational load-use comparator between ID sources and EX dest.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  wire logic [4:0] i_id_rs1,
    input  wire logic [4:0] i_id_rs2,
    input  wire logic       i_id_rs1_used,
    input  wire logic       i_id_rs2_used,
    input  wire logic [4:0] i_ex_rd,
    input  wire logic       i_ex_we,
    input  wire logic       i_ex_is_load,
    output logic            o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    // x0 is hard-wired zero, so a load targeting it never produces a hazard
    assign o_load_use = i_ex_is_load && i_ex_we && (i_ex_rd != REG_X0)
                        && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module : pipeline_hazard_ctrl
// Brief  : Stall/flush controller: load-use, mem wait with timeout, redirects.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int              WAIT_W       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]      c_FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [1:0]          r_flush_cnt;
    logic                r_timeout_err;
    logic [CNT_W-1:0]    r_stall_cycles;

    logic w_load_use;
    logic w_timeout_hit;
    logic w_mem_stall;
    logic w_redirect_now;
    logic w_stop;
    logic w_freeze;
    logic w_flush_if_id;
    logic w_flush_id_ex;
    logic [3:0] w_info;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_rs1_used (bus.id_rs1_used),
        .i_id_rs2_used (bus.id_rs2_used),
        .i_ex_rd       (bus.ex_rd),
        .i_ex_we       (bus.ex_we),
        .i_ex_is_load  (bus.ex_is_load),
        .o_load_use    (w_load_use)
    );

    assign w_timeout_hit  = (r_state == ST_MEM_WAIT) && (r_wait_cnt == c_WAIT_LAST);
    assign w_mem_stall    = bus.mem_req && !bus.mem_ack && !w_timeout_hit;
    // EX is frozen during a mem stall, so a deferred redirect is still presented later
    assign w_redirect_now = bus.ex_redirect && !w_mem_stall;

    // The RUN cycle that starts a wait counts as the first stalled cycle, so the
    // release lands on the MEM_TIMEOUT-th consecutive cycle of the access.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else begin
                    w_wait_nxt  = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack || w_timeout_hit) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_stop        = 1'b0;
        w_freeze      = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_info        = STOP_NONE;
        if (!rst) begin
            if (w_mem_stall) begin
                w_stop   = 1'b1;
                w_freeze = 1'b1;
                w_info   = STOP_MEMWAIT;
            end else if (w_redirect_now || (r_flush_cnt != 2'd0)) begin
                // load-use against a wrong-path instruction is irrelevant
                w_flush_if_id = 1'b1;
                w_flush_id_ex = w_redirect_now;
                w_info        = STOP_FLUSH;
            end else if (w_load_use) begin
                w_stop        = 1'b1;
                w_flush_id_ex = 1'b1;
                w_info        = STOP_LOADUSE;
            end
            if (w_timeout_hit) begin
                w_info = STOP_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_flush_cnt    <= 2'd0;
            r_timeout_err  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_redirect_now) begin
                r_flush_cnt <= c_FLUSH_INIT;
            end else if ((r_flush_cnt != 2'd0) && !w_mem_stall) begin
                r_flush_cnt <= r_flush_cnt - 2'd1;
            end
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
            if (w_stop && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign bus.pipeline_stop = w_stop;
    assign bus.freeze_all    = w_freeze;
    assign bus.flush_if_id   = w_flush_if_id;
    assign bus.flush_id_ex   = w_flush_id_ex;
    assign bus.stop_info     = w_info;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.stall_cycles  = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipeline_hazard_ctrl
// Brief  : Directed self-checking bench for pipeline_hazard_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_cnt;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .MEM_TIMEOUT  (8),
        .CNT_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       exp_stop;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs1 = 5'd0;  bus.id_rs2 = 5'd0;
        bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
        bus.ex_rd = 5'd0;   bus.ex_we = 1'b0; bus.ex_is_load = 1'b0;
        bus.ex_redirect = 1'b0; bus.mem_req = 1'b0; bus.mem_ack = 1'b0;
    endtask

    task automatic set_load_use();
        bus.ex_is_load = 1'b1; bus.ex_we = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs2 = 5'd5; bus.id_rs2_used = 1'b1;
    endtask

    task automatic chk_out(input string nm, input logic stop, input logic frz,
                           input logic fif, input logic fie, input logic [3:0] info);
        chk({nm, ".stop"},  bus.pipeline_stop, stop);
        chk({nm, ".frz"},   bus.freeze_all,    frz);
        chk({nm, ".fifid"}, bus.flush_if_id,   fif);
        chk({nm, ".fidex"}, bus.flush_id_ex,   fie);
        chk({nm, ".info"},  bus.stop_info,     info);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //            rs1    rs2    u1    u2    rd     we    ld    stop
        vecs[0] = '{5'd0,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1};
        vecs[1] = '{5'd0,  5'd0,  1'b0, 1'b1, 5'd0,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1};
        vecs[3] = '{5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0};
        vecs[4] = '{5'd3,  5'd4,  1'b1, 1'b1, 5'd7,  1'b1, 1'b1, 1'b0};
        vecs[5] = '{5'd0,  5'd9,  1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0};
        vecs[6] = '{5'd0,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0};
        vecs[7] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{5'd0,  5'd1,  1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 1'b0};

        // Reset held: outputs must be quiet even with a load-use on the inputs
        rst = 1'b1;
        idle();
        set_load_use();
        #3;
        chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        chk("rst_hold.terr", bus.timeout_err, 1'b0);
        chk("rst_hold.cnt",  bus.stall_cycles, 32'd0);
        do_reset();

        // Load-use table, one vector per cycle
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.id_rs1 = vecs[i].rs1; bus.id_rs2 = vecs[i].rs2;
            bus.id_rs1_used = vecs[i].u1; bus.id_rs2_used = vecs[i].u2;
            bus.ex_rd = vecs[i].rd; bus.ex_we = vecs[i].we; bus.ex_is_load = vecs[i].ld;
            #1;
            chk_out($sformatf("lu%0d", i), vecs[i].exp_stop, 1'b0, 1'b0,
                    vecs[i].exp_stop, vecs[i].exp_stop ? 4'b0001 : 4'b0000);
            chk($sformatf("lu%0d.cnt", i), bus.stall_cycles, exp_cnt);
            if (vecs[i].exp_stop) exp_cnt++;
        end
        @(negedge clk);
        idle();
        #1;
        chk("lu.cnt_final", bus.stall_cycles, exp_cnt);

        // Mem wait: 4 unacked cycles, then ack
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
            #1;
            chk_out($sformatf("mw%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010);
        end
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        chk_out("mw_ack", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        idle();
        #1;
        chk("mw.cnt", bus.stall_cycles, 32'd4);

        // Timeout: never acked, release on the 8th cycle
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.mem_req = 1'b1; bus.mem_ack = 1'b0;
            #1;
            chk_out($sformatf("to%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010);
        end
        @(negedge clk);
        #1;
        chk_out("to8", 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
        chk("to8.terr", bus.timeout_err, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("to.terr_set", bus.timeout_err, 1'b1);
        chk("to.cnt", bus.stall_cycles, 32'd7);
        repeat (3) @(negedge clk);
        #1;
        chk("to.terr_sticky", bus.timeout_err, 1'b1);

        // Async reset in the middle of a mem wait clears everything at once
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_req = 1'b1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk_out("arst", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        chk("arst.terr", bus.timeout_err, 1'b0);
        chk("arst.cnt", bus.stall_cycles, 32'd0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        // A fresh wait must again last a full 7 stalled cycles
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.mem_req = 1'b1;
            #1;
            chk($sformatf("arst_to%0d.stop", k), bus.pipeline_stop, 1'b1);
        end
        @(negedge clk);
        #1;
        chk("arst_to8.info", bus.stop_info, 4'b1000);

        // Redirect with concurrent load-use: 2-cycle flush, no stall
        do_reset();
        @(negedge clk);
        set_load_use();
        bus.ex_redirect = 1'b1;
        #1;
        chk_out("rd0", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100);
        @(negedge clk);
        bus.ex_redirect = 1'b0;
        #1;
        chk_out("rd1", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100);
        @(negedge clk);
        #1;
        chk_out("rd2", 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001);
        @(negedge clk);
        idle();
        #1;
        chk("rd.cnt", bus.stall_cycles, 32'd1);

        // Redirect arriving during a mem stall is deferred until ack
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.mem_req = 1'b1; bus.mem_ack = 1'b0; bus.ex_redirect = 1'b1;
            #1;
            chk_out($sformatf("rms%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010);
        end
        @(negedge clk);
        bus.mem_ack = 1'b1;
        #1;
        chk_out("rms_ack", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100);
        @(negedge clk);
        idle();
        #1;
        chk_out("rms_f2", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100);
        @(negedge clk);
        #1;
        chk_out("rms_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage core.
- Drives the freeze input of the IF/ID register and PC (pipeline_stop plus the 4-bit stop-reason code), and the flush/bubble controls for IF/ID and ID/EX.
- Resolves load-use hazards, data-memory wait stalls with timeout, and branch/jump redirect flushes with a programmable flush window.
- Keeps a sticky timeout error and a stall-cycle performance counter.

Parameters:
- FLUSH_CYCLES, 1, cycles flush_if_id stays asserted after a redirect (range 1..3; covers imem latency).
- MEM_TIMEOUT, 255, max consecutive cycles in MEM_WAIT before forced release.
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_rs1  in  5  ID-stage source reg 1
- id_rs2  in  5  ID-stage source reg 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination reg
- ex_we  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch/jump (PC redirect this cycle)
- mem_req  in  1  MEM stage data access pending
- mem_ack  in  1  data memory completes access this cycle
- pipeline_stop  out  1  freeze PC and IF/ID (hold values)
- stop_info  out  4  stop/flush reason code
- flush_if_id  out  1  load NOP into IF/ID
- flush_id_ex  out  1  insert bubble into ID/EX
- freeze_all  out  1  freeze ID/EX, EX/MEM, MEM/WB (mem wait)
- timeout_err  out  1  sticky, set on MEM_TIMEOUT expiry
- stall_cycles  out  CNT_W  count of cycles with pipeline_stop=1

Behaviour:
- Reset (asynchronous, active-high, rst; clock clk): state=RUN, wait_cnt=0, flush_cnt=0, timeout_err=0, stall_cycles=0. All combinational outputs evaluate to 0 while rst is held.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req & ~mem_ack.
  - MEM_WAIT -> RUN on mem_ack, or when wait_cnt==MEM_TIMEOUT-1 (timeout).
  - wait_cnt clears on entering RUN and increments each MEM_WAIT cycle.
- mem_stall = mem_req & ~mem_ack & ~timeout_hit. Combinational, same cycle, in both states. timeout_hit = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
- On timeout_hit:
  - timeout_err <= 1 (cleared only by rst).
  - Pipeline is released this cycle.
  - stop_info=4'b1000 for that cycle.
- load_use = ex_is_load & ex_we & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- redirect_now = ex_redirect & ~mem_stall. A redirect during a mem stall is deferred; EX is frozen, so ex_redirect stays asserted.
- On redirect_now, flush_cnt <= FLUSH_CYCLES-1. flush_cnt decrements when nonzero and ~mem_stall.
- Priority, highest first:
  - mem_stall: pipeline_stop=1, freeze_all=1, flush_*=0, stop_info=4'b0010.
  - redirect_now or flush_cnt!=0: flush_if_id=1, pipeline_stop=0. flush_id_ex=redirect_now (wrong-path ID instruction killed). stop_info=4'b0100. A simultaneous load_use is ignored (wrong path).
  - load_use: pipeline_stop=1, flush_id_ex=1, stop_info=4'b0001. This lasts exactly one cycle naturally, because the load advances to MEM.
  - otherwise: all 0, stop_info=4'b0000.
- x0 never causes a hazard.
- stall_cycles increments each cycle pipeline_stop=1 and saturates at all-ones.
- Latency: all stop/flush outputs are combinational from current inputs and registered state (zero-cycle); state and counters update on posedge clk.

Decomposition:
- Shared package/defines: stop_info codes STOP_NONE=0001? No — STOP_NONE=4'b0000, STOP_LOADUSE=4'b0001, STOP_MEMWAIT=4'b0010, STOP_FLUSH=4'b0100, STOP_TIMEOUT=4'b1000; FSM state encodings; REG_X0=5'd0.
- One sub-module, hazard_detect: the combinational load_use comparator, reusable for future forwarding logic.
- FSM and counters stay in the top.

Test Plan:
- Load-use: ex_is_load=1, ex_we=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> exactly one cycle with pipeline_stop=1, flush_id_ex=1, stop_info=0001; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Mem wait: mem_req=1 with mem_ack low 4 cycles, then high -> pipeline_stop=freeze_all=1 for 4 cycles, stop_info=0010, released the cycle ack=1; stall_cycles=4.
- Timeout (MEM_TIMEOUT=8): mem_req=1, never acked -> stall 7 cycles, cycle 8 stop_info=1000, pipeline_stop=0, timeout_err=1 sticky until rst.
- Redirect with FLUSH_CYCLES=2 -> flush_if_id=1 for 2 cycles, flush_id_ex=1 first cycle only, pipeline_stop=0; a concurrent load_use produces no stall.
- Redirect during mem stall: ex_redirect=1 while mem_req&~mem_ack for 3 cycles -> no flush during stall; flush starts the cycle mem_ack=1.
- Reset mid-MEM_WAIT: assert rst asynchronously -> outputs 0 immediately, state RUN, counters 0, timeout_err=0.
